// File: rtl/fft_if_pkg.sv
// fft_if_pkg: shared types and constants for the FFT host-side interface
package fft_if_pkg;
  typedef enum logic [1:0] {IDLE, READY, DRAIN} rd_state_t;
  localparam int RESULT_ADDR_BITS = 9;
  localparam int STATUS_SEL_BIT = RESULT_ADDR_BITS;
  localparam int ERR_CLR_BIT = 2;
  localparam int RD_LATENCY = 2;
  localparam int ST_READY_BIT = 0;
  localparam int ST_DRAIN_BIT = 1;
  localparam int ST_ERR_BIT = 2;
endpackage

// File: rtl/result_counter.sv
// result_counter: modulo-N up-counter tracking legal result reads in a frame
module result_counter #(
  parameter int W = 9,
  parameter int N = 512
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         count_en,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         last,
  output logic         rollover_flag
);
  assign last = count == W'(N - 1);
  assign rollover_flag = count_en & last;
  always_ff @(posedge clk)
    if (!n_rst || clear) count <= '0;
    else if (count_en) count <= rollover_flag ? '0 : count + 1'b1;
endmodule

// File: rtl/fft_result_reader.sv
// fft_result_reader: Avalon-MM read slave returning FFT results with 2-cycle latency
module fft_result_reader
  import fft_if_pkg::*;
#(
  parameter int ADDR_BITS = RESULT_ADDR_BITS,
  parameter int NUM_SAMPLES = 512,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rEn,
  input  logic                 wEn,
  input  logic [63:0]          address,
  input  logic [DATA_W-1:0]    wData,
  output logic [DATA_W-1:0]    rData,
  output logic                 rDataValid,
  input  logic                 fft_done,
  output logic                 ram_rd_en,
  output logic [ADDR_BITS-1:0] ram_addr,
  input  logic [DATA_W-1:0]    ram_data,
  output logic                 read_done
);
  rd_state_t state, state_d;
  logic is_stat, data_rd, legal, illegal, err, err_clr, rollover;
  logic v1, legal1, last1;
  logic [DATA_W-1:0] word1, status;
  logic [ADDR_BITS-1:0] count_unused;
  logic last_unused, unused;
  assign is_stat = address[ADDR_BITS];
  assign data_rd = rEn & ~is_stat;
  assign legal = data_rd & (state == READY);
  assign illegal = data_rd & (state != READY);
  assign err_clr = wEn & is_stat & wData[ERR_CLR_BIT];
  assign ram_rd_en = legal;
  assign ram_addr = address[ADDR_BITS-1:0];
  assign unused = ^{address[63:ADDR_BITS+1], wData[DATA_W-1:ERR_CLR_BIT+1], wData[ERR_CLR_BIT-1:0]};
  always_comb begin
    status = '0;
    status[ST_READY_BIT] = state == READY;
    status[ST_DRAIN_BIT] = state == DRAIN;
    status[ST_ERR_BIT] = err;
  end
  result_counter #(.W(ADDR_BITS), .N(NUM_SAMPLES)) u_cnt (
    .clk(clk),
    .n_rst(n_rst),
    .count_en(legal),
    .clear(rollover),
    .count(count_unused),
    .last(last_unused),
    .rollover_flag(rollover)
  );
  // rollover can only fire in READY, since only legal reads advance the counter
  always_comb begin
    state_d = (state == IDLE && fft_done) ? READY :
              rollover                    ? DRAIN :
              (state == DRAIN && last1)   ? IDLE  : state;
  end
  always_ff @(posedge clk)
    if (!n_rst) begin
      state <= IDLE;
      err <= 1'b0;
      v1 <= 1'b0;
      legal1 <= 1'b0;
      last1 <= 1'b0;
      word1 <= '0;
      rData <= '0;
      rDataValid <= 1'b0;
      read_done <= 1'b0;
    end else begin
      state <= state_d;
      err <= illegal | (err & ~err_clr);
      v1 <= rEn;
      legal1 <= legal;
      last1 <= rollover;
      word1 <= (rEn & is_stat) ? status : '0;
      rDataValid <= v1;
      rData <= legal1 ? ram_data : word1;
      read_done <= last1;
    end
endmodule

// File: doc/fft_result_reader.md
Name: fft_result_reader

Overview:
- Avalon-MM read-side slave. Returns FFT output samples from the result RAM to the host after the FFT core signals completion.
- Counterpart of the write-side loader, which fills the input buffer and pulses fft_start.
- Fixed 2-cycle pipelined read latency, one read accepted per cycle, plus one status word.
- After all NUM_SAMPLES result reads, pulses read_done so the loader/FFT can be rearmed.

Parameters:
- ADDR_BITS, 9, result RAM address width.
- NUM_SAMPLES, 512, result words per frame; equals 2**ADDR_BITS.
- DATA_W, 32, sample/readdata width.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  synchronous active-low reset, sampled on rising clk.
- rEn  in  1  Avalon read strobe.
- wEn  in  1  Avalon write strobe; used only for the status clear.
- address  in  64  Avalon address. Bits [ADDR_BITS-1:0] = sample index; bit [ADDR_BITS] = status select; all other bits ignored.
- wData  in  DATA_W  write data; only bit 2 is used (status clear).
- rData  out  DATA_W  read data.
- rDataValid  out  1  rData qualifier.
- fft_done  in  1  one-cycle pulse from FFT core: results are in RAM.
- ram_rd_en  out  1  result RAM read enable.
- ram_addr  out  ADDR_BITS  result RAM address.
- ram_data  in  DATA_W  RAM output, valid 1 cycle after ram_rd_en.
- read_done  out  1  one-cycle pulse: frame fully read out.

Behaviour:
- Reset (n_rst=0 at a clk edge):
  - State goes to IDLE.
  - Registered outputs clear: rData=0, rDataValid=0, read_done=0.
  - Pipeline valid bits, counter and err flag clear.
  - Reset mid-frame discards in-flight reads: rDataValid is 0 on the cycle after the reset edge.
- States: IDLE, READY, DRAIN.
  - IDLE -> READY when fft_done=1.
  - READY -> DRAIN on the cycle the NUM_SAMPLES-th data read is accepted.
  - DRAIN -> IDLE when the last pipelined data read reaches rDataValid. read_done=1 on that same cycle.
- Accept rule:
  - Every cycle with rEn=1 is accepted; no waitrequest.
  - A read is a data read if address[ADDR_BITS]=0, otherwise a status read.
- Pipeline, for an accept in cycle T:
  - Stage 1, cycle T: ram_rd_en=1 and ram_addr=address[ADDR_BITS-1:0] (combinational), only for data reads in READY. Request tag {kind, legal} is registered.
  - Stage 2: at edge T+2, rData and rDataValid are registered, so rData is valid in cycle T+2. rData = ram_data for a legal data read, status word for a status read, 0 for an illegal data read.
  - Back-to-back reads produce back-to-back rDataValid.
- Legal data read: state is READY.
  - Data reads in IDLE or DRAIN return 0 with rDataValid=1 and set the sticky err flag.
  - These reads do not touch the RAM or the counter.
- Status word, sampled in the accept cycle: {29'b0, err, state==DRAIN, state==READY}.
- Status clear: wEn=1 with address[ADDR_BITS]=1 and wData[2]=1 clears err. All other writes are ignored. If an err set and a clear happen in the same cycle, set wins.
- Counter:
  - Counts legal data reads modulo NUM_SAMPLES. Addresses need not be sequential or unique; only the count matters.
  - Clears on the READY->DRAIN transition and on reset.
- Simultaneous events:
  - fft_done outside IDLE is ignored; no state change.
  - fft_done and rEn in the same IDLE cycle: the read is illegal (state is still IDLE).
- read_done is high for exactly one cycle per frame.

Decomposition:
- Package fft_if_pkg holds:
  - reader state enum {IDLE, READY, DRAIN};
  - localparams STATUS_SEL_BIT = ADDR_BITS, ERR_CLR_BIT = 2, RD_LATENCY = 2;
  - status bit positions.
- Sub-module result_counter: synchronous-reset, modulo-NUM_SAMPLES up-counter with inputs count_en and clear, a rollover_flag output, and a combinational last flag meaning count==NUM_SAMPLES-1. The FSM, pipeline and status logic stay in fft_result_reader.

Test Plan:
- Reset then fft_done pulse, then 512 back-to-back data reads at addresses 0..511 with RAM model data = 0xA5000000|addr -> rData sequence 0xA5000000..0xA50001FF, each 2 cycles after its read. read_done pulses in the same cycle as the last rDataValid. State returns to IDLE.
- Data read at address 5 while IDLE -> rData=0 and rDataValid 2 cycles later, ram_rd_en stays 0. A following status read (address 0x200) returns 0x4.
- Write address 0x200 with wData=0x4, then status read -> 0x0. Repeat with err set and clear in the same cycle -> status read returns 0x4.
- fft_done, 100 reads, status read -> 0x1. Then n_rst=0 for 1 cycle mid-burst -> rDataValid=0 the next cycle, status read afterward returns 0x0, and a fresh fft_done plus 512 reads completes with a single read_done.
- Second fft_done pulse while READY after 10 reads -> ignored. Exactly 502 more reads still produce read_done.
- Interleaved status and data reads, 512 data reads total -> status reads do not advance the counter. read_done fires only after the 512th data read's valid.
